// File: rtl/wb_mem_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_mem_slave_if : WISHBONE classic slave-slot signal bundle           |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface wb_mem_slave_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_mem_slave : WISHBONE classic responder, byte-writable RAM, waits   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module wb_mem_slave #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  wire             clk,
  input  wire             rst_n,
  wb_mem_slave_if.slave   bus
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [3:0]          wait_cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_idx;
  logic [1:0]          lat_lo;
  logic [31:0]         lat_dat;
  logic [3:0]          lat_sel;
  logic                ack_reg;
  logic                err_reg;
  logic [31:0]         dat_reg;

  logic                req;
  logic                enter_resp;
  logic                cur_we;
  logic [ADDR_W-1:0]   cur_idx;
  logic [1:0]          cur_lo;
  logic [31:0]         cur_dat;
  logic [3:0]          cur_sel;
  logic                misaligned;
  logic                mem_we;
  logic                rd_en;
  logic                unused_adr_bits;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  assign req = (state == IDLE) && bus.wb_cyc_i && bus.wb_stb_i;

  // With zero wait states RESP is entered on the request edge itself, so the
  // live bus values stand in for the not-yet-latched copies.
  always_comb begin
    cur_we  = lat_we;
    cur_idx = lat_idx;
    cur_lo  = lat_lo;
    cur_dat = lat_dat;
    cur_sel = lat_sel;
    if (state == IDLE) begin
      cur_we  = bus.wb_we_i;
      cur_idx = bus.wb_adr_i[ADDR_W+1:2];
      cur_lo  = bus.wb_adr_i[1:0];
      cur_dat = bus.wb_dat_i;
      cur_sel = bus.wb_sel_i;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!(bus.wb_cyc_i && bus.wb_stb_i)) begin
          next_state = IDLE;
        end else if (wait_cnt == 4'd0) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign enter_resp = (next_state == RESP);
  assign misaligned = (cur_lo != 2'b00);
  assign mem_we     = enter_resp && cur_we && !misaligned && rst_n;
  assign rd_en      = enter_resp && !cur_we && !misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
      lat_we   <= 1'b0;
      lat_idx  <= '0;
      lat_lo   <= 2'b00;
      lat_dat  <= 32'd0;
      lat_sel  <= 4'd0;
      ack_reg  <= 1'b0;
      err_reg  <= 1'b0;
      dat_reg  <= 32'd0;
    end else begin
      if (req) begin
        lat_we  <= bus.wb_we_i;
        lat_idx <= bus.wb_adr_i[ADDR_W+1:2];
        lat_lo  <= bus.wb_adr_i[1:0];
        lat_dat <= bus.wb_dat_i;
        lat_sel <= bus.wb_sel_i;
      end
      if (state == IDLE && next_state == WAIT) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      ack_reg <= enter_resp && !misaligned;
      err_reg <= enter_resp && misaligned;
      if (rd_en) begin
        dat_reg <= mem[cur_idx];
      end
    end
  end

  // RAM contents survive reset; only lanes with sel set are updated.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) begin
          mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
        end
      end
    end
  end

  assign bus.wb_ack_o = ack_reg;
  assign bus.wb_err_o = err_reg;
  assign bus.wb_dat_o = dat_reg;

  assign unused_adr_bits = ^bus.wb_adr_i[31:ADDR_W+2];

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_mem_slave : directed bench for wb_mem_slave at 0/1/3 waits     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_wb_mem_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0: WAIT_CYCLES=1, index 1: WAIT_CYCLES=3, index 2: WAIT_CYCLES=0
  logic [2:0]  cyc = '0;
  logic [2:0]  stb = '0;
  logic [2:0]  we  = '0;
  logic [31:0] adr [3];
  logic [31:0] wdat[3];
  logic [3:0]  sel [3];
  logic [31:0] rdat[3];
  logic [2:0]  ack;
  logic [2:0]  err;

  int n_cmp = 0;
  int n_err = 0;

  wb_mem_slave_if bus_w1();
  wb_mem_slave_if bus_w3();
  wb_mem_slave_if bus_w0();

  assign bus_w1.wb_cyc_i = cyc[0];
  assign bus_w1.wb_stb_i = stb[0];
  assign bus_w1.wb_we_i  = we[0];
  assign bus_w1.wb_adr_i = adr[0];
  assign bus_w1.wb_dat_i = wdat[0];
  assign bus_w1.wb_sel_i = sel[0];
  assign rdat[0] = bus_w1.wb_dat_o;
  assign ack[0]  = bus_w1.wb_ack_o;
  assign err[0]  = bus_w1.wb_err_o;

  assign bus_w3.wb_cyc_i = cyc[1];
  assign bus_w3.wb_stb_i = stb[1];
  assign bus_w3.wb_we_i  = we[1];
  assign bus_w3.wb_adr_i = adr[1];
  assign bus_w3.wb_dat_i = wdat[1];
  assign bus_w3.wb_sel_i = sel[1];
  assign rdat[1] = bus_w3.wb_dat_o;
  assign ack[1]  = bus_w3.wb_ack_o;
  assign err[1]  = bus_w3.wb_err_o;

  assign bus_w0.wb_cyc_i = cyc[2];
  assign bus_w0.wb_stb_i = stb[2];
  assign bus_w0.wb_we_i  = we[2];
  assign bus_w0.wb_adr_i = adr[2];
  assign bus_w0.wb_dat_i = wdat[2];
  assign bus_w0.wb_sel_i = sel[2];
  assign rdat[2] = bus_w0.wb_dat_o;
  assign ack[2]  = bus_w0.wb_ack_o;
  assign err[2]  = bus_w0.wb_err_o;

  wb_mem_slave #(.ADDR_W(10), .WAIT_CYCLES(1)) dut_w1 (.clk(clk), .rst_n(rst_n), .bus(bus_w1));
  wb_mem_slave #(.ADDR_W(10), .WAIT_CYCLES(3)) dut_w3 (.clk(clk), .rst_n(rst_n), .bus(bus_w3));
  wb_mem_slave #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_w0 (.clk(clk), .rst_n(rst_n), .bus(bus_w0));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // One classic transfer; lat is the edge index (request edge = 0) at which
  // the master samples ack/err high, or -1 on timeout.
  task automatic do_xfer(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] dw, input logic [3:0] s,
                         output int lat, output logic got_ack, output logic got_err,
                         output logic [31:0] rd, output logic term_after);
    lat = -1; got_ack = 1'b0; got_err = 1'b0; rd = 32'd0; term_after = 1'b1;
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dw; sel[d] = s;
    @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      if (ack[d] || err[d]) begin
        lat = k; got_ack = ack[d]; got_err = err[d]; rd = rdat[d];
        break;
      end
      @(posedge clk); #1;
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      term_after = ack[d] | err[d];
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
  endtask

  int          lat;
  logic        ga, ge, ta;
  logic [31:0] rd;
  int          n_ack;
  logic [31:0] burst_exp [4];

  initial begin
    for (int i = 0; i < 3; i++) begin
      adr[i] = 32'd0; wdat[i] = 32'd0; sel[i] = 4'd0;
    end
    #22;
    check_val("reset_ack", {31'd0, ack[0]}, 32'd0);
    check_val("reset_err", {31'd0, err[0]}, 32'd0);
    check_val("reset_dat", rdat[0], 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Full write then read, WAIT_CYCLES=1
    do_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, ga, ge, rd, ta);
    check_val("wr_lat", lat, 32'd2);
    check_val("wr_ack", {31'd0, ga}, 32'd1);
    check_val("wr_ack_pulse", {31'd0, ta}, 32'd0);
    do_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, ga, ge, rd, ta);
    check_val("rd_lat", lat, 32'd2);
    check_val("rd_data", rd, 32'hDEADBEEF);

    // Byte lanes 0 and 2; dat_o must not follow a write
    do_xfer(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, lat, ga, ge, rd, ta);
    check_val("bl_dat_hold", rdat[0], 32'hDEADBEEF);
    do_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, ga, ge, rd, ta);
    check_val("bl_data", rd, 32'hDE22BE44);

    do_xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, ga, ge, rd, ta);
    check_val("sel0_ack", {31'd0, ga}, 32'd1);
    do_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, ga, ge, rd, ta);
    check_val("sel0_data", rd, 32'hDE22BE44);

    // Misaligned read and write
    do_xfer(0, 1'b0, 32'h12, 32'h0, 4'hF, lat, ga, ge, rd, ta);
    check_val("mis_rd_err", {31'd0, ge}, 32'd1);
    check_val("mis_rd_ack", {31'd0, ga}, 32'd0);
    check_val("mis_rd_lat", lat, 32'd2);
    check_val("mis_rd_pulse", {31'd0, ta}, 32'd0);
    check_val("mis_rd_dat", rdat[0], 32'hDE22BE44);
    do_xfer(0, 1'b1, 32'h11, 32'h00000000, 4'hF, lat, ga, ge, rd, ta);
    check_val("mis_wr_err", {31'd0, ge}, 32'd1);
    do_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, ga, ge, rd, ta);
    check_val("mis_wr_data", rd, 32'hDE22BE44);

    // Aliasing modulo 4*1024 bytes
    do_xfer(0, 1'b0, 32'h1010, 32'h0, 4'hF, lat, ga, ge, rd, ta);
    check_val("alias_rd", rd, 32'hDE22BE44);
    do_xfer(0, 1'b1, 32'hFFFF_F014, 32'hCAFEF00D, 4'hF, lat, ga, ge, rd, ta);
    do_xfer(0, 1'b0, 32'h14, 32'h0, 4'hF, lat, ga, ge, rd, ta);
    check_val("alias_wr", rd, 32'hCAFEF00D);

    // Zero-wait burst: ack every other cycle with cyc/stb held high
    burst_exp[0] = 32'h01010101; burst_exp[1] = 32'h20202020;
    burst_exp[2] = 32'h0300C003; burst_exp[3] = 32'hF00FF00F;
    for (int i = 0; i < 4; i++) begin
      do_xfer(2, 1'b1, 32'(4*i), burst_exp[i], 4'hF, lat, ga, ge, rd, ta);
    end
    check_val("w0_lat", lat, 32'd1);
    @(posedge clk); #1;
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 32'h0;
    n_ack = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (err[2]) check_val("burst_err", {31'd0, err[2]}, 32'd0);
      if (ack[2]) begin
        if (n_ack < 4) begin
          check_val($sformatf("burst_data%0d", n_ack), rdat[2], burst_exp[n_ack]);
          check_val($sformatf("burst_cycle%0d", n_ack), c, 32'(2*n_ack));
        end
        n_ack++;
        if (n_ack >= 4) begin
          cyc[2] = 1'b0; stb[2] = 1'b0;
        end else begin
          adr[2] = 32'(4*n_ack);
        end
      end
    end
    check_val("burst_count", n_ack, 32'd4);

    // Abort during WAIT, WAIT_CYCLES=3
    do_xfer(1, 1'b1, 32'h40, 32'hAAAA5555, 4'hF, lat, ga, ge, rd, ta);
    check_val("w3_wr_lat", lat, 32'd4);
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h40;
    wdat[1] = 32'h12345678; sel[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb[1] = 1'b0;
    n_ack = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ack[1] || err[1]) n_ack++;
    end
    cyc[1] = 1'b0; we[1] = 1'b0;
    check_val("abort_no_term", n_ack, 32'd0);
    do_xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, lat, ga, ge, rd, ta);
    check_val("abort_next_lat", lat, 32'd4);
    check_val("abort_data", rd, 32'hAAAA5555);

    // Reset asserted during WAIT of a write
    do_xfer(1, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, lat, ga, ge, rd, ta);
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h20;
    wdat[1] = 32'h55AA55AA; sel[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_dat", rdat[1], 32'd0);
    check_val("rst_mid_ack", {31'd0, ack[1]}, 32'd0);
    check_val("rst_mid_err", {31'd0, err[1]}, 32'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    do_xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, lat, ga, ge, rd, ta);
    check_val("rst_drop_lat", lat, 32'd4);
    check_val("rst_drop_data", rd, 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the bench always ends on its own
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
